sparc_ifu_thrsched: RTL and testbench
=====================================

Name: sparc_ifu_thrsched

Overview:
- Thread scheduler for the 4-thread IFU; produces the per-thread schedule and switch_out strobes that drive each thread's thread-state FSM.
- Consumes the 4 five-bit thread states those FSMs return.
- Picks among ready threads with round-robin fairness and enforces a run quantum.
- Reports the currently running thread to fetch control.

Parameters:
- QUANTUM_W, 4, width of the run-quantum counter.
- QUANTUM, 8, cycles a thread may run before a forced switch when another thread is ready; legal range 1..2^QUANTUM_W-1.

Ports:
- clk  input  1  core clock
- arst_l  input  1  asynchronous active-low reset
- thr_state  input  20  thread states, thread t in bits [5t+4:5t]; bit 4 set = ready (RDY/SPEC_RDY), bit 2 set = running (RUN/SPEC_RUN)
- stall_s  input  1  pipeline stall; no schedule or switch_out issued while high
- force_switch  input  1  request an immediate switch, e.g. interrupt pending; single-cycle pulse
- schedule  output  4  one-hot pulse, thread switched in this cycle
- switch_out  output  4  one-hot pulse, running thread switched out to ready this cycle
- cur_thr  output  2  id of the current or last running thread
- cur_vld  output  1  a scheduled thread is believed running

Behaviour:
- Reset:
  - arst_l low asynchronously clears FSM to NONE.
  - schedule=0, switch_out=0, cur_thr=0, cur_vld=0.
  - Quantum counter = 0; rr_ptr = 3, so the first pick favours thread 0.
- Registered outputs: all outputs come from flops.
  - Strobes are one cycle wide, asserted in the cycle after the decision.
  - The thread FSM then updates state on the following edge.
- Round-robin pick: first ready thread scanning rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4), excluding cur_thr when in RUN. rr_ptr is updated to the picked id on every issued schedule.
- FSM states:
  - NONE:
    - If ~stall_s and any thread is ready: pulse schedule[pick], set cur_thr=pick, cur_vld=1, load counter=QUANTUM, go to GRANT.
    - Otherwise stay.
  - GRANT: one-cycle wait for the thread state to reflect the schedule pulse.
    - If thr_state[cur].bit2 is set: go to RUN.
    - Else (stall raced the grant): cur_vld=0, go to NONE.
  - RUN:
    - Counter decrements when ~stall_s, saturating at 0.
    - If thr_state[cur].bit2 clears (thread went WAIT/HALT/RDY on its own): cur_vld=0, go to NONE. No switch_out is issued. This check takes priority over everything below.
    - Else if (counter==0 or force_switch) and ~stall_s and another thread is ready: pulse switch_out[cur] and schedule[pick] in the same cycle, cur_thr=pick, reload counter, go to GRANT.
    - Else if counter==0 and no other thread is ready: reload counter and stay; force_switch is dropped.
- Invariants:
  - schedule and switch_out never flag the same thread.
  - At most one bit set in each.
  - schedule never targets a thread whose ready bit is clear in the decision cycle.
- stall_s high freezes counter and decisions. Bit-2 drop detection still acts during stall.
- Illegal thr_state encodings are treated by their bits only; no special case.
- Reset mid-switch: strobes are cleared immediately; no partial pulse survives.

Decomposition:
- Shared header ifu.h provides:
  - THRFSM_* state encodings.
  - Ready/running bit positions (TCR_READY=4, TCR_RUN=2).
- One natural combinational sub-module: sparc_ifu_rrpick4 (4 ready bits + rr_ptr + exclude mask -> 2-bit pick, pick_vld).
- Counter and FSM stay in the top module.

Test Plan:
- Reset then thread 2 RDY (11001), others IDLE -> schedule=0100 one cycle later, cur_thr=2, cur_vld=1; model drives state RUN -> FSM in RUN.
- Threads 0 and 1 RDY from NONE, QUANTUM=8 -> thread 0 scheduled, then after 8 unstalled RUN cycles switch_out=0001 with schedule=0010 in the same cycle, cur_thr=1.
- Only thread 3 ready and running, quantum expires -> no strobes, counter reloads, cur_thr stays 3.
- Thread 1 running, force_switch pulse with thread 2 SPEC_RDY (10011) -> switch_out=0010, schedule=0100 next cycle.
- stall_s held 5 cycles at quantum expiry with another thread ready -> no strobes during stall; switch issues the cycle after stall_s drops.
- Running thread's state drops to WAIT (00001) -> cur_vld=0, no switch_out; next ready thread gets schedule one cycle after the NONE entry; arst_l asserted mid-switch clears all strobes immediately.

Source files
------------

// File: rtl/sparc_ifu_thrsched_pkg.sv
// sparc_ifu_thrsched_pkg: thread-state encodings, status bit positions and scheduler FSM states.
package sparc_ifu_thrsched_pkg;
  localparam int TCR_READY = 4;
  localparam int TCR_RUN = 2;
  localparam logic [4:0] THRFSM_IDLE = 5'b00000;
  localparam logic [4:0] THRFSM_WAIT = 5'b00001;
  localparam logic [4:0] THRFSM_HALT = 5'b00010;
  localparam logic [4:0] THRFSM_RDY = 5'b11001;
  localparam logic [4:0] THRFSM_SPEC_RDY = 5'b10011;
  localparam logic [4:0] THRFSM_RUN = 5'b00101;
  localparam logic [4:0] THRFSM_SPEC_RUN = 5'b00111;
  typedef enum logic [1:0] {ST_NONE, ST_GRANT, ST_RUN} thr_fsm_e;
endpackage

// File: rtl/sparc_ifu_rrpick4.sv
// sparc_ifu_rrpick4: first ready, non-excluded thread scanning rr_ptr+1, +2, +3, rr_ptr.
module sparc_ifu_rrpick4 (
  input  logic [3:0] ready,
  input  logic [1:0] rr_ptr,
  input  logic [3:0] excl,
  output logic [1:0] pick,
  output logic       pick_vld
);
  logic [3:0] cand;
  logic [1:0] idx;
  assign cand = ready & ~excl;
  // Scan farthest offset first so the nearest candidate overwrites and wins.
  always_comb begin
    pick = 2'd0;
    pick_vld = 1'b0;
    idx = rr_ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = rr_ptr + 2'(i);
      if (cand[idx]) begin
        pick = idx;
        pick_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sparc_ifu_thrsched.sv
// sparc_ifu_thrsched: round-robin 4-thread scheduler with run quantum,
// emitting registered schedule/switch_out strobes to the thread FSMs.
module sparc_ifu_thrsched
  import sparc_ifu_thrsched_pkg::*;
#(
  parameter int QUANTUM_W = 4,
  parameter int QUANTUM = 8
) (
  input  logic        clk,
  input  logic        arst_l,
  input  logic [19:0] thr_state,
  input  logic        stall_s,
  input  logic        force_switch,
  output logic [3:0]  schedule,
  output logic [3:0]  switch_out,
  output logic [1:0]  cur_thr,
  output logic        cur_vld
);
  localparam logic [QUANTUM_W-1:0] QLOAD = QUANTUM_W'(QUANTUM);
  thr_fsm_e state, state_nx;
  logic [QUANTUM_W-1:0] cnt, cnt_nx;
  logic [1:0] rr_ptr, rr_nx, cur_nx, pick;
  logic [3:0] ready, running, excl, sched_nx, swo_nx;
  logic vld_nx, pick_vld, cur_run, unused_bits;
  for (genvar t = 0; t < 4; t++) begin : g_bits
    assign ready[t] = thr_state[5*t+TCR_READY];
    assign running[t] = thr_state[5*t+TCR_RUN];
  end
  assign unused_bits = ^thr_state;
  assign cur_run = running[cur_thr];
  assign excl = (state == ST_RUN) ? 4'b0001 << cur_thr : 4'b0000;
  sparc_ifu_rrpick4 u_pick (
    .ready(ready),
    .rr_ptr(rr_ptr),
    .excl(excl),
    .pick(pick),
    .pick_vld(pick_vld)
  );
  // GRANT holds while its schedule pulse is out, then checks the thread reached RUN.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    rr_nx = rr_ptr;
    cur_nx = cur_thr;
    vld_nx = cur_vld;
    sched_nx = 4'b0000;
    swo_nx = 4'b0000;
    case (state)
      ST_NONE:
        if (!stall_s && pick_vld) begin
          sched_nx = 4'b0001 << pick;
          cur_nx = pick;
          rr_nx = pick;
          vld_nx = 1'b1;
          cnt_nx = QLOAD;
          state_nx = ST_GRANT;
        end
      ST_GRANT:
        if (~|schedule) begin
          state_nx = cur_run ? ST_RUN : ST_NONE;
          vld_nx = cur_run;
        end
      ST_RUN:
        if (!cur_run) begin
          vld_nx = 1'b0;
          state_nx = ST_NONE;
        end else if (!stall_s) begin
          if ((cnt == '0 || force_switch) && pick_vld) begin
            swo_nx = 4'b0001 << cur_thr;
            sched_nx = 4'b0001 << pick;
            cur_nx = pick;
            rr_nx = pick;
            cnt_nx = QLOAD;
            state_nx = ST_GRANT;
          end else begin
            cnt_nx = (cnt == '0) ? QLOAD : cnt - 1'b1;
          end
        end
      default: state_nx = ST_NONE;
    endcase
  end
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state <= ST_NONE;
      cnt <= '0;
      rr_ptr <= 2'd3;
      cur_thr <= 2'd0;
      cur_vld <= 1'b0;
      schedule <= 4'b0000;
      switch_out <= 4'b0000;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      rr_ptr <= rr_nx;
      cur_thr <= cur_nx;
      cur_vld <= vld_nx;
      schedule <= sched_nx;
      switch_out <= swo_nx;
    end
  end
endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// tb_sparc_ifu_thrsched: directed scenarios plus randomized run against a cycle-level
// reference model; the bench also plays the four thread FSMs.
module tb_sparc_ifu_thrsched;
  localparam int Q = 8;
  localparam logic [4:0] IDLE = 5'b00000, WAIT = 5'b00001, RDY = 5'b11001;
  localparam logic [4:0] SRDY = 5'b10011, RUN = 5'b00101;
  logic clk = 1'b0;
  logic arst_l = 1'b0;
  logic [19:0] thr_state = '0;
  logic stall_s = 1'b0, force_switch = 1'b0;
  logic [3:0] schedule, switch_out;
  logic [1:0] cur_thr;
  logic cur_vld;
  logic [10:0] obs, want;
  int checks = 0, errors = 0;
  int m_phase, m_gwait, m_left, m_rr, m_cur;
  logic m_vld;
  logic [3:0] m_sched, m_swo;

  always #5 clk = ~clk;
  assign obs = {schedule, switch_out, cur_thr, cur_vld};

  sparc_ifu_thrsched #(.QUANTUM_W(4), .QUANTUM(Q)) dut (
    .clk(clk),
    .arst_l(arst_l),
    .thr_state(thr_state),
    .stall_s(stall_s),
    .force_switch(force_switch),
    .schedule(schedule),
    .switch_out(switch_out),
    .cur_thr(cur_thr),
    .cur_vld(cur_vld)
  );

  task automatic set_thr(input int t, input logic [4:0] s);
    thr_state[5*t +: 5] = s;
  endtask

  function automatic int rr_pick(input int ptr, input logic [3:0] rdy, input int skip);
    for (int k = 1; k <= 4; k++) begin
      int t;
      t = (ptr + k) % 4;
      if (rdy[t] && t != skip) return t;
    end
    return -1;
  endfunction

  task automatic grant(input int p);
    m_sched[p] = 1'b1;
    m_cur = p;
    m_rr = p;
    m_vld = 1'b1;
    m_left = Q;
    m_phase = 1;
    m_gwait = 1;
  endtask

  // Reference decision for the coming edge: phase 0 idle, 1 granting, 2 running.
  task automatic model_eval();
    logic [3:0] rdy, run;
    int p;
    for (int t = 0; t < 4; t++) begin
      rdy[t] = thr_state[5*t+4];
      run[t] = thr_state[5*t+2];
    end
    m_sched = '0;
    m_swo = '0;
    if (m_phase == 0) begin
      p = stall_s ? -1 : rr_pick(m_rr, rdy, -1);
      if (p >= 0) grant(p);
    end else if (m_phase == 1) begin
      if (m_gwait > 0) m_gwait--;
      else begin
        m_vld = run[m_cur];
        m_phase = run[m_cur] ? 2 : 0;
      end
    end else if (!run[m_cur]) begin
      m_vld = 1'b0;
      m_phase = 0;
    end else if (!stall_s) begin
      p = rr_pick(m_rr, rdy, m_cur);
      if ((m_left == 0 || force_switch) && p >= 0) begin
        m_swo[m_cur] = 1'b1;
        grant(p);
      end else m_left = (m_left == 0) ? Q : m_left - 1;
    end
  endtask

  // One clock: model decides, edge, then thread FSMs act on the strobes that were live.
  task automatic cyc();
    logic [3:0] ps, pw;
    ps = m_sched;
    pw = m_swo;
    model_eval();
    @(posedge clk);
    #1;
    for (int t = 0; t < 4; t++) begin
      if (pw[t]) set_thr(t, RDY);
      if (ps[t]) set_thr(t, RUN);
    end
    force_switch = 1'b0;
  endtask

  task automatic test_reset();
    arst_l = 1'b0;
    thr_state = '0;
    stall_s = 1'b0;
    force_switch = 1'b0;
    m_phase = 0; m_gwait = 0; m_left = 0; m_rr = 3; m_cur = 0;
    m_vld = 1'b0; m_sched = '0; m_swo = '0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", obs, 11'b0);
    end
    @(negedge clk);
    arst_l = 1'b1;
  endtask

  task automatic test_first_pick();
    test_reset();
    set_thr(2, RDY);
    cyc();
    want = {4'b0100, 4'b0000, 2'd2, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL first_pick_sched got %b want %b", obs, want); end
    repeat (3) cyc();
    want = {4'b0000, 4'b0000, 2'd2, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL first_pick_run got %b want %b", obs, want); end
  endtask

  task automatic test_quantum();
    test_reset();
    set_thr(0, RDY);
    set_thr(1, RDY);
    cyc();
    want = {4'b0001, 4'b0000, 2'd0, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL quantum_first got %b want %b", obs, want); end
    repeat (10) cyc();
    want = {4'b0000, 4'b0000, 2'd0, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL quantum_early got %b want %b", obs, want); end
    cyc();
    want = {4'b0010, 4'b0001, 2'd1, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL quantum_switch got %b want %b", obs, want); end
  endtask

  task automatic test_solo_expiry();
    test_reset();
    set_thr(3, RDY);
    cyc();
    want = {4'b1000, 4'b0000, 2'd3, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL solo_sched got %b want %b", obs, want); end
    repeat (2) cyc();
    for (int i = 0; i < 9; i++) begin
      cyc();
      want = {4'b0000, 4'b0000, 2'd3, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL solo_hold cyc %0d got %b want %b", i, obs, want); end
    end
    set_thr(0, RDY);
    repeat (8) cyc();
    want = {4'b0000, 4'b0000, 2'd3, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL solo_reload got %b want %b", obs, want); end
    cyc();
    want = {4'b0001, 4'b1000, 2'd0, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL solo_after_reload got %b want %b", obs, want); end
  endtask

  task automatic test_force();
    test_reset();
    set_thr(1, RDY);
    repeat (3) cyc();
    set_thr(2, SRDY);
    repeat (2) cyc();
    want = {4'b0000, 4'b0000, 2'd1, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL force_before got %b want %b", obs, want); end
    force_switch = 1'b1;
    cyc();
    want = {4'b0100, 4'b0010, 2'd2, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL force_switch got %b want %b", obs, want); end
  endtask

  task automatic test_stall();
    test_reset();
    set_thr(0, RDY);
    set_thr(1, RDY);
    repeat (11) cyc();
    stall_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      want = {4'b0000, 4'b0000, 2'd0, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL stall_hold cyc %0d got %b want %b", i, obs, want); end
    end
    stall_s = 1'b0;
    cyc();
    want = {4'b0010, 4'b0001, 2'd1, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL stall_release got %b want %b", obs, want); end
  endtask

  task automatic test_drop_and_reset();
    test_reset();
    set_thr(0, RDY);
    repeat (4) cyc();
    set_thr(0, WAIT);
    set_thr(1, RDY);
    cyc();
    want = {4'b0000, 4'b0000, 2'd0, 1'b0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL drop_none got %b want %b", obs, want); end
    cyc();
    want = {4'b0010, 4'b0000, 2'd1, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL drop_resched got %b want %b", obs, want); end
    #2;
    arst_l = 1'b0;
    #1;
    checks++;
    if (obs !== 11'b0) begin errors++; $display("FAIL async_reset got %b want %b", obs, 11'b0); end
    test_reset();
  endtask

  task automatic test_random();
    logic [4:0] pool [4];
    pool = '{IDLE, WAIT, RDY, SRDY};
    test_reset();
    for (int n = 0; n < 3000; n++) begin
      stall_s = ($urandom_range(0, 7) == 0);
      force_switch = ($urandom_range(0, 11) == 0);
      for (int t = 0; t < 4; t++)
        if (!m_sched[t] && !m_swo[t] && $urandom_range(0, 15) == 0)
          set_thr(t, pool[$urandom_range(0, 3)]);
      cyc();
      want = {m_sched, m_swo, 2'(m_cur), m_vld};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL random cyc %0d got %b want %b", n, obs, want); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_pick();
    test_quantum();
    test_solo_expiry();
    test_force();
    test_stall();
    test_drop_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
